// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef logic [1:0] owner_t;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_WAIT = 1'b1;

   localparam owner_t OWN_NONE = 2'd0;
   localparam owner_t OWN_I    = 2'd1;
   localparam owner_t OWN_D    = 2'd2;

   localparam logic [3:0]  MASK_ALL      = 4'b1111;
   localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational owner select, data over instruction by default;
// ARB_ROUND_ROBIN_EN breaks ties against the previous owner instead.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   output logic [1:0] grant,
   input  logic       i_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       d_req,
   input  logic [1:0] last_owner
`else
   input  logic       d_req
`endif
);

`ifdef ARB_ROUND_ROBIN_EN
   assign grant = (i_req && d_req) ? (last_owner == OWN_D ? OWN_I : OWN_D) :
                  d_req ? OWN_D : i_req ? OWN_I : OWN_NONE;
`else
   assign grant = d_req ? OWN_D : i_req ? OWN_I : OWN_NONE;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory_top between fetch and load/store ports with a WAIT watchdog.
// Optional ARB_ROUND_ROBIN_EN swaps fixed data priority for tie alternation.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we_re,
   input  logic [3:0]        d_mask,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_request,
   output logic              mem_we_re,
   output logic [3:0]        mem_masking,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_w_data,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_r_data,
   output logic              busy,
   output logic              timeout_err
);

   localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

   logic              state;
   logic [1:0]        owner;
   logic [1:0]        grant;
   logic [CW-1:0]     cnt;
   logic              abort;
   logic              done;
   logic              take;
   logic [DATA_W-1:0] rdata_n;

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] last_owner;

   // Reset to instr so the very first tie goes to the data port.
   always_ff @(posedge clk or posedge rst)
      if (rst) last_owner <= OWN_I;
      else if (take) last_owner <= grant;

   mem_arb_grant u_grant (
      .grant      (grant),
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_owner)
   );
`else
   mem_arb_grant u_grant (
      .grant (grant),
      .i_req (i_req),
      .d_req (d_req)
   );
`endif

   // Abort fires on the last permitted WAIT cycle, so the counter never reaches wrap.
   assign abort   = TIMEOUT_CYC != 0 && cnt == TERM && !mem_valid;
   assign done    = state == ST_WAIT && (mem_valid || abort);
   assign take    = state == ST_IDLE && grant != OWN_NONE;
   assign rdata_n = mem_valid ? mem_r_data : DATA_W'(TIMEOUT_RDATA);

   assign mem_request = state == ST_WAIT;
   assign busy        = state != ST_IDLE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= OWN_NONE;
         cnt         <= '0;
         mem_we_re   <= 1'b0;
         mem_masking <= '0;
         mem_address <= '0;
         mem_w_data  <= '0;
         i_valid     <= 1'b0;
         d_valid     <= 1'b0;
         i_rdata     <= '0;
         d_rdata     <= '0;
         timeout_err <= 1'b0;
      end else begin
         i_valid <= done && owner == OWN_I;
         d_valid <= done && owner == OWN_D;
         if (take) begin
            state       <= ST_WAIT;
            owner       <= grant;
            cnt         <= '0;
            mem_we_re   <= grant == OWN_D && d_we_re;
            mem_masking <= grant == OWN_D ? d_mask : MASK_ALL;
            mem_address <= grant == OWN_D ? d_addr : i_addr;
            mem_w_data  <= grant == OWN_D ? d_wdata : '0;
         end else if (done) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            if (owner == OWN_I) i_rdata <= rdata_n;
            else d_rdata <= rdata_n;
            if (!mem_valid) timeout_err <= 1'b1;
         end else if (state == ST_WAIT && TIMEOUT_CYC != 0) begin
            cnt <= cnt + 1'b1;
         end
      end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with expected-response and expected-command scoreboards.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [3:0]  mask;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic        d;
      logic [31:0] data;
   } rsp_t;

   logic        clk, rst;
   logic        i_req, i_valid;
   logic [7:0]  i_addr;
   logic [31:0] i_rdata;
   logic        d_req, d_we_re, d_valid;
   logic [3:0]  d_mask;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata, d_rdata;
   logic        mem_request, mem_we_re, mem_valid;
   logic [3:0]  mem_masking;
   logic [7:0]  mem_address;
   logic [31:0] mem_w_data, mem_r_data;
   logic        busy, timeout_err;

   logic [31:0] mem [256];
   cmd_t        cmd_q [$];
   rsp_t        rsp_q [$];
   logic        stray, mem_hang;
   int          mem_lat;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_masking(mem_masking),
      .mem_address(mem_address), .mem_w_data(mem_w_data),
      .mem_valid(mem_valid), .mem_r_data(mem_r_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_rsp(input logic d, input string nm, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(d ? d_valid : i_valid) && cyc < 200);
      n_chk++;
      if (!(d ? d_valid : i_valid)) begin
         n_fail++;
         $display("FAIL %s: no valid after %0d cycles", nm, cyc);
      end
   endtask

   task automatic fetch(input logic [7:0] a, input logic [31:0] exp, input int lat);
      int c;
      cmd_q.push_back({1'b0, 4'hF, a, 32'h0});
      rsp_q.push_back({1'b0, exp});
      i_addr = a;
      i_req  = 1'b1;
      wait_rsp(1'b0, "fetch_wait", c);
      i_req  = 1'b0;
      chk("fetch_latency", 64'(c), 64'(lat));
   endtask

   task automatic dacc(input logic we, input logic [3:0] m, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input int lat);
      int c;
      cmd_q.push_back({we, m, a, wd});
      rsp_q.push_back({1'b1, exp});
      d_we_re = we;
      d_mask  = m;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
      wait_rsp(1'b1, "data_wait", c);
      d_req   = 1'b0;
      chk("data_latency", 64'(c), 64'(lat));
   endtask

   // Memory model: checks each command on its first WAIT cycle, answers mem_lat cycles later.
   initial begin
      logic        in_txn;
      int          wn;
      cmd_t        cur, e;
      logic [31:0] old;
      mem_valid  = 1'b0;
      mem_r_data = 32'h0;
      in_txn     = 1'b0;
      wn         = 0;
      cur        = '0;
      forever begin
         @(posedge clk); #2;
         if (!mem_request) begin
            in_txn     = 1'b0;
            mem_valid  = stray;
            mem_r_data = stray ? 32'h5A5A5A5A : 32'hDEADBEEF;
         end else begin
            if (!in_txn) begin
               in_txn = 1'b1;
               wn     = 0;
               cur    = {mem_we_re, mem_masking, mem_address, mem_w_data};
               if (cmd_q.size() == 0) chk("cmd_unexpected", 64'(cur), 64'h0);
               else begin
                  e = cmd_q.pop_front();
                  chk("cmd", 64'(cur), 64'(e));
               end
            end else wn++;
            if (!mem_hang && wn == mem_lat) begin
               chk("cmd_stable", 64'({mem_we_re, mem_masking, mem_address, mem_w_data}), 64'(cur));
               old = mem[mem_address];
               if (mem_we_re)
                  for (int b = 0; b < 4; b++)
                     if (mem_masking[b]) mem[mem_address][8*b +: 8] = mem_w_data[8*b +: 8];
               mem_r_data = old;
               mem_valid  = 1'b1;
            end else begin
               mem_valid  = 1'b0;
               mem_r_data = 32'hDEADBEEF;
            end
         end
      end
   end

   initial begin
      rsp_t e;
      forever begin
         @(posedge clk); #1;
         if (i_valid || d_valid) begin
            chk("valid_exclusive", 64'(i_valid && d_valid), 64'h0);
            if (rsp_q.size() == 0) chk("valid_unexpected", 64'({i_valid, d_valid}), 64'h0);
            else begin
               e = rsp_q.pop_front();
               chk("rsp_port", 64'(d_valid), 64'(e.d));
               chk("rsp_data", 64'(d_valid ? d_rdata : i_rdata), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we_re = 1'b0;
      d_mask = '0; d_addr = '0; d_wdata = '0; stray = 1'b0; mem_hang = 1'b0; mem_lat = 0;
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[8'h04] = 32'h00500093;
      mem[8'h08] = 32'h00A00113;
      mem[8'h0C] = 32'h00000013;
      mem[8'h10] = 32'h11111111;
      mem[8'h20] = 32'hA0A0A0A0;
      mem[8'h24] = 32'hB1B1B1B1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_mem_cmd", 64'({mem_request, mem_we_re, mem_masking, mem_address, mem_w_data}), 64'h0);
      chk("reset_valids_err", 64'({i_valid, d_valid, timeout_err}), 64'h0);
      chk("reset_rdata", {i_rdata, d_rdata}, 64'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      stray = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stray_busy", 64'(busy), 64'h0);
         chk("stray_valids", 64'({i_valid, d_valid}), 64'h0);
      end
      stray = 1'b0;
      @(posedge clk); #1;

      mem_lat = 0;
      fetch(8'h04, 32'h00500093, 2);
      mem_lat = 2;
      dacc(1'b1, 4'b0011, 8'h10, 32'hCAFEBABE, 32'h11111111, 4);
      mem_lat = 1;
      dacc(1'b0, 4'hF, 8'h10, 32'h12345678, 32'h1111BABE, 3);

      chk("err_before_timeout", 64'(timeout_err), 64'h0);
      mem_hang = 1'b1;
      dacc(1'b0, 4'hF, 8'h20, 32'h12345678, 32'h0, 5);
      mem_hang = 1'b0;
      chk("timeout_err_set", 64'(timeout_err), 64'h1);
      fetch(8'h08, 32'h00A00113, 3);
      chk("timeout_err_sticky", 64'(timeout_err), 64'h1);

      mem_hang = 1'b1;
      cmd_q.push_back({1'b0, 4'hF, 8'h30, 32'h0});
      i_addr = 8'h30;
      i_req  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midwait_busy", 64'({busy, mem_request}), 64'h3);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_mem", 64'({mem_request, busy, mem_we_re, mem_masking, mem_address}), 64'h0);
      chk("async_rst_valids_err", 64'({i_valid, d_valid, timeout_err}), 64'h0);
      chk("async_rst_rdata", {i_rdata, d_rdata}, 64'h0);
      i_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_hang = 1'b0;
      mem_lat = 0;
      fetch(8'h04, 32'h00500093, 2);

`ifdef ARB_ROUND_ROBIN_EN
      cmd_q.push_back({1'b0, 4'hF, 8'h20, 32'h12345678}); rsp_q.push_back({1'b1, 32'hA0A0A0A0});
      cmd_q.push_back({1'b0, 4'hF, 8'h08, 32'h0});        rsp_q.push_back({1'b0, 32'h00A00113});
      cmd_q.push_back({1'b0, 4'hF, 8'h24, 32'h12345678}); rsp_q.push_back({1'b1, 32'hB1B1B1B1});
      cmd_q.push_back({1'b0, 4'hF, 8'h0C, 32'h0});        rsp_q.push_back({1'b0, 32'h00000013});
`else
      cmd_q.push_back({1'b0, 4'hF, 8'h20, 32'h12345678}); rsp_q.push_back({1'b1, 32'hA0A0A0A0});
      cmd_q.push_back({1'b0, 4'hF, 8'h24, 32'h12345678}); rsp_q.push_back({1'b1, 32'hB1B1B1B1});
      cmd_q.push_back({1'b0, 4'hF, 8'h08, 32'h0});        rsp_q.push_back({1'b0, 32'h00A00113});
      cmd_q.push_back({1'b0, 4'hF, 8'h0C, 32'h0});        rsp_q.push_back({1'b0, 32'h00000013});
`endif
      d_we_re = 1'b0;
      d_mask  = 4'hF;
      d_wdata = 32'h12345678;
      fork
         begin
            int c;
            d_addr = 8'h20;
            d_req  = 1'b1;
            wait_rsp(1'b1, "tie_d0_wait", c);
            d_addr = 8'h24;
            wait_rsp(1'b1, "tie_d1_wait", c);
            d_req  = 1'b0;
         end
         begin
            int c;
            i_addr = 8'h08;
            i_req  = 1'b1;
            wait_rsp(1'b0, "tie_i0_wait", c);
            i_addr = 8'h0C;
            wait_rsp(1'b0, "tie_i1_wait", c);
            i_req  = 1'b0;
         end
      join

      repeat (4) @(posedge clk);
      #1;
      chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
      chk("cmd_queue_drained", 64'(cmd_q.size()), 64'h0);
      chk("idle_at_end", 64'({busy, mem_request}), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
